// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: round-robin instr/data OBI arbiter onto one memory port.
// Optional starvation guard enabled by defining OBI_ARB_FAIRNESS_EN.
module obi_mem_arbiter #(
  parameter int unsigned RESP_LAT  = 1,
  parameter int unsigned STALL_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_owner_o
);

  if (RESP_LAT < 1 || RESP_LAT > 7) begin : g_bad_lat
    $error("RESP_LAT out of range 1..7");
  end
  if (STALL_MAX < 1 || STALL_MAX > 15) begin : g_bad_stall
    $error("STALL_MAX out of range 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic        owner_q;
  logic        wr_q;
  logic        last_q;
  logic        permit;
  logic        grant;
  logic        pick_data;
  logic        resp_done;
  logic        rvalid;

`ifdef OBI_ARB_FAIRNESS_EN
  logic [3:0]  wait_q;
  logic [3:0]  wait_d;
`endif

  // Grant decision, winner selection and response timing.
  always_comb begin
    cnt_d     = cnt_q + 3'd1;
`ifdef OBI_ARB_FAIRNESS_EN
    wait_d    = wait_q + 4'd1;
    permit    = !mem_stall_i || (wait_q == 4'(STALL_MAX));
`else
    permit    = !mem_stall_i;
`endif
    pick_data = data_req_i && (!instr_req_i || !last_q);
    grant     = (state_q == IDLE) && !reset &&
                (instr_req_i || data_req_i) && permit;
    resp_done = (state_q == RESP) && (cnt_q == 3'(RESP_LAT));
    rvalid    = resp_done && !reset;
  end

  // Memory port and handshake outputs; all zero outside grant/rvalid.
  always_comb begin
    instr_gnt_o    = grant && !pick_data;
    data_gnt_o     = grant && pick_data;
    mem_en_o       = grant;
    mem_owner_o    = grant && pick_data;
    mem_we_o       = 1'b0;
    mem_addr_o     = 32'h0;
    mem_be_o       = 4'h0;
    mem_wdata_o    = 32'h0;
    if (grant) begin
      if (pick_data) begin
        mem_we_o    = data_we_i;
        mem_addr_o  = data_addr_i & 32'hFFFF_FFFC;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i & 32'hFFFF_FFFC;
        mem_be_o    = 4'hF;
      end
    end
    instr_rvalid_o = rvalid && !owner_q;
    data_rvalid_o  = rvalid && owner_q;
    instr_rdata_o  = (instr_rvalid_o && !wr_q) ? mem_rdata_i : 32'h0;
    data_rdata_o   = (data_rvalid_o && !wr_q) ? mem_rdata_i : 32'h0;
  end

  // IDLE/RESP state machine with round-robin pointer and wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= 1'b0;
`ifdef OBI_ARB_FAIRNESS_EN
      wait_q  <= 4'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= RESP;
            cnt_q   <= 3'd1;
            owner_q <= pick_data;
            wr_q    <= pick_data && data_we_i;
            last_q  <= pick_data;
          end
`ifdef OBI_ARB_FAIRNESS_EN
          if (grant) begin
            wait_q <= 4'd0;
          end else if (instr_req_i || data_req_i) begin
            wait_q <= wait_d;
          end
`endif
        end
        RESP: begin
          if (resp_done) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

endmodule
